// File: rtl/id_issue_pkg.sv
// Shared decode/issue definitions: ALU op codes, RV32I opcode fields and the
// decoded bundle handed to EX.
package id_issue_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD         = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB         = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND         = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR          = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR         = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LT          = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NONE        = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_LEFT  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_RIGHT = 4'd8;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [ALU_OP_W-1:0] aluop;
    logic                alusrc;
    logic [XLEN-1:0]     imme;
    logic                memwrite;
    logic                memread;
    logic                regwrite;
    logic                branch;
    logic                branch_ne;
    logic                illegal;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [REG_AW-1:0]   rd;
  } id_bundle_t;

  localparam id_bundle_t BUNDLE_RST = '{aluop: ALU_OP_NONE, default: '0};

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/id_issue_if.sv
// Fetch-side and EX-side handshake bundle of the decode/issue stage.
interface id_issue_if;
  import id_issue_pkg::*;

  logic [XLEN-1:0]     IF_inst;
  logic                IF_valid;
  logic                IF_ready;
  logic                ID_flush;
  logic                ID_valid;
  logic                ID_ready;
  logic [ALU_OP_W-1:0] ID_aluop;
  logic                ID_alusrc;
  logic [XLEN-1:0]     ID_imme;
  logic                ID_memwrite;
  logic                ID_memread;
  logic                ID_regwrite;
  logic                ID_branch;
  logic                ID_branch_ne;
  logic                ID_illegal;
  logic [REG_AW-1:0]   ID_rs1;
  logic [REG_AW-1:0]   ID_rs2;
  logic [REG_AW-1:0]   ID_rd;

  modport master (
    output IF_inst, IF_valid, ID_flush, ID_ready,
    input  IF_ready, ID_valid, ID_aluop, ID_alusrc, ID_imme, ID_memwrite,
           ID_memread, ID_regwrite, ID_branch, ID_branch_ne, ID_illegal,
           ID_rs1, ID_rs2, ID_rd
  );

  modport slave (
    input  IF_inst, IF_valid, ID_flush, ID_ready,
    output IF_ready, ID_valid, ID_aluop, ID_alusrc, ID_imme, ID_memwrite,
           ID_memread, ID_regwrite, ID_branch, ID_branch_ne, ID_illegal,
           ID_rs1, ID_rs2, ID_rd
  );

endinterface

// File: rtl/id_decode.sv
// Purely combinational RV32I subset decoder producing the EX control bundle.
module id_decode
  import id_issue_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output id_bundle_t      bundle_c
);

  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [XLEN-1:0]     imm_i;
  logic [XLEN-1:0]     imm_s;
  logic [XLEN-1:0]     imm_b;
  logic [XLEN-1:0]     imm_sh;

  logic                legal;
  logic [ALU_OP_W-1:0] aluop;
  logic                alusrc;
  logic [XLEN-1:0]     imme;
  logic                memwrite;
  logic                memread;
  logic                regwrite;
  logic                branch;
  logic                branch_ne;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = sext12(inst[31:20]);
  assign imm_s  = sext12({inst[31:25], inst[11:7]});
  assign imm_b  = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_sh = {(XLEN-5)'(0), inst[24:20]};

  always_comb begin
    legal     = 1'b0;
    aluop     = ALU_OP_NONE;
    alusrc    = 1'b0;
    imme      = '0;
    memwrite  = 1'b0;
    memread   = 1'b0;
    regwrite  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;

    case (opcode)
      OPC_R: begin
        legal    = 1'b1;
        regwrite = 1'b1;
        case (f3)
          F3_ADD_SUB: begin
            if (f7 == F7_ZERO)     aluop = ALU_OP_ADD;
            else if (f7 == F7_ALT) aluop = ALU_OP_SUB;
            else                   legal = 1'b0;
          end
          F3_AND: aluop = ALU_OP_AND;
          F3_OR:  aluop = ALU_OP_OR;
          F3_XOR: aluop = ALU_OP_XOR;
          F3_SLT: aluop = ALU_OP_LT;
          F3_SLL: begin
            if (f7 == F7_ZERO) aluop = ALU_OP_SHIFT_LEFT;
            else               legal = 1'b0;
          end
          F3_SRL: begin
            if (f7 == F7_ZERO) aluop = ALU_OP_SHIFT_RIGHT;
            else               legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_I_ALU: begin
        legal    = 1'b1;
        alusrc   = 1'b1;
        regwrite = 1'b1;
        imme     = imm_i;
        case (f3)
          F3_ADD_SUB: aluop = ALU_OP_ADD;
          F3_AND:     aluop = ALU_OP_AND;
          F3_OR:      aluop = ALU_OP_OR;
          F3_XOR:     aluop = ALU_OP_XOR;
          F3_SLT:     aluop = ALU_OP_LT;
          // Immediate shifts carry only a shamt; srai-style upper bits are rejected.
          F3_SLL: begin
            imme = imm_sh;
            if (f7 == F7_ZERO) aluop = ALU_OP_SHIFT_LEFT;
            else               legal = 1'b0;
          end
          F3_SRL: begin
            imme = imm_sh;
            if (f7 == F7_ZERO) aluop = ALU_OP_SHIFT_RIGHT;
            else               legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        if (f3 == F3_LW) begin
          legal    = 1'b1;
          aluop    = ALU_OP_ADD;
          alusrc   = 1'b1;
          memread  = 1'b1;
          regwrite = 1'b1;
          imme     = imm_i;
        end
      end
      OPC_STORE: begin
        if (f3 == F3_SW) begin
          legal    = 1'b1;
          aluop    = ALU_OP_ADD;
          alusrc   = 1'b1;
          memwrite = 1'b1;
          imme     = imm_s;
        end
      end
      OPC_BRANCH: begin
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          legal     = 1'b1;
          aluop     = ALU_OP_SUB;
          branch    = 1'b1;
          branch_ne = f3[0];
          imme      = imm_b;
        end
      end
      default: legal = 1'b0;
    endcase

    bundle_c     = BUNDLE_RST;
    bundle_c.rs1 = inst[19:15];
    bundle_c.rs2 = inst[24:20];
    bundle_c.rd  = inst[11:7];
    if (legal) begin
      bundle_c.aluop     = aluop;
      bundle_c.alusrc    = alusrc;
      bundle_c.imme      = imme;
      bundle_c.memwrite  = memwrite;
      bundle_c.memread   = memread;
      bundle_c.regwrite  = regwrite;
      bundle_c.branch    = branch;
      bundle_c.branch_ne = branch_ne;
    end else begin
      bundle_c.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/id_issue.sv
// Registered decode/issue stage: valid/ready intake, output register, flush.
// Define ID_SKID_EN for a 1-entry skid register and a registered IF_ready.
module id_issue
  import id_issue_pkg::*;
#(
  parameter bit NOP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  id_issue_if.slave   bus
);

  id_bundle_t dec_c;
  id_bundle_t out_q;
  logic       out_valid_q;
  logic       if_ready_c;
  logic       out_free_c;
  logic       accept_c;
  logic       keep_c;

  id_decode u_decode (
    .inst     (bus.IF_inst),
    .bundle_c (dec_c)
  );

  assign out_free_c = ~out_valid_q | bus.ID_ready;
  assign accept_c   = bus.IF_valid & if_ready_c;
  // Dropped illegal words are consumed from fetch but never stored.
  assign keep_c     = accept_c & (NOP_ILLEGAL | ~dec_c.illegal);

`ifdef ID_SKID_EN
  id_bundle_t skid_q;
  logic       skid_valid_q;
  logic       if_ready_q;

  // Flush overrides the registered ready so nothing is accepted and then discarded.
  assign if_ready_c = if_ready_q & ~bus.ID_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= BUNDLE_RST;
      out_valid_q  <= 1'b0;
      skid_q       <= BUNDLE_RST;
      skid_valid_q <= 1'b0;
      if_ready_q   <= 1'b1;
    end else if (bus.ID_flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      if_ready_q   <= 1'b1;
    end else if (out_free_c) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        if_ready_q   <= 1'b1;
      end else begin
        out_valid_q  <= keep_c;
        if (keep_c) out_q <= dec_c;
      end
    end else if (keep_c) begin
      skid_q       <= dec_c;
      skid_valid_q <= 1'b1;
      if_ready_q   <= 1'b0;
    end
  end
`else
  assign if_ready_c = out_free_c & ~bus.ID_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= BUNDLE_RST;
      out_valid_q <= 1'b0;
    end else if (bus.ID_flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free_c) begin
      out_valid_q <= keep_c;
      if (keep_c) out_q <= dec_c;
    end
  end
`endif

  assign bus.IF_ready     = if_ready_c;
  assign bus.ID_valid     = out_valid_q;
  assign bus.ID_aluop     = out_q.aluop;
  assign bus.ID_alusrc    = out_q.alusrc;
  assign bus.ID_imme      = out_q.imme;
  assign bus.ID_memwrite  = out_q.memwrite;
  assign bus.ID_memread   = out_q.memread;
  assign bus.ID_regwrite  = out_q.regwrite;
  assign bus.ID_branch    = out_q.branch;
  assign bus.ID_branch_ne = out_q.branch_ne;
  assign bus.ID_illegal   = out_q.illegal;
  assign bus.ID_rs1       = out_q.rs1;
  assign bus.ID_rs2       = out_q.rs2;
  assign bus.ID_rd        = out_q.rd;

endmodule

// File: tb/tb_id_issue.sv
// Scoreboard bench for id_issue: one DUT issuing illegal words as NOPs, one dropping them.
module tb_id_issue;

  localparam int NW = 11;
`ifdef ID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_inst = '0;
  logic        if_valid = 1'b0;
  logic        id_flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        sel = 1'b0;

  logic [31:0] insts [NW];
  logic [57:0] exps  [NW];
  logic        ills  [NW];
  logic [57:0] cur_exp = '0;
  logic        cur_ill = 1'b0;
  int          cur = 0;

  logic [57:0] qa [$];
  logic [57:0] qb [$];
  int          n_err = 0;
  int          n_checks = 0;

  id_issue_if bus_a ();
  id_issue_if bus_b ();

  assign bus_a.IF_inst  = if_inst;
  assign bus_a.IF_valid = if_valid & ~sel;
  assign bus_a.ID_flush = id_flush;
  assign bus_a.ID_ready = id_ready;
  assign bus_b.IF_inst  = if_inst;
  assign bus_b.IF_valid = if_valid & sel;
  assign bus_b.ID_flush = id_flush;
  assign bus_b.ID_ready = id_ready;

  id_issue #(.NOP_ILLEGAL(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  id_issue #(.NOP_ILLEGAL(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [57:0] bun(input logic [3:0] aluop, input logic alusrc,
      input logic [31:0] imme, input logic mw, input logic mr, input logic rw,
      input logic br, input logic bne, input logic ill,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {aluop, alusrc, imme, mw, mr, rw, br, bne, ill, rs1, rs2, rd};
  endfunction

  function automatic logic [57:0] obs_a();
    return {bus_a.ID_aluop, bus_a.ID_alusrc, bus_a.ID_imme, bus_a.ID_memwrite,
            bus_a.ID_memread, bus_a.ID_regwrite, bus_a.ID_branch, bus_a.ID_branch_ne,
            bus_a.ID_illegal, bus_a.ID_rs1, bus_a.ID_rs2, bus_a.ID_rd};
  endfunction

  function automatic logic [57:0] obs_b();
    return {bus_b.ID_aluop, bus_b.ID_alusrc, bus_b.ID_imme, bus_b.ID_memwrite,
            bus_b.ID_memread, bus_b.ID_regwrite, bus_b.ID_branch, bus_b.ID_branch_ne,
            bus_b.ID_illegal, bus_b.ID_rs1, bus_b.ID_rs2, bus_b.ID_rd};
  endfunction

  function automatic logic sel_if_ready();
    return sel ? bus_b.IF_ready : bus_a.IF_ready;
  endfunction

  task automatic set_entry(input int i, input logic [31:0] w, input logic [57:0] e, input logic il);
    insts[i] = w;
    exps[i]  = e;
    ills[i]  = il;
  endtask

  task automatic load(input int i);
    if_inst = insts[i];
    cur_exp = exps[i];
    cur_ill = ills[i];
  endtask

  // One cycle of driving: present word cur (if any left), advance on handshake.
  task automatic tick_drive(input int last);
    logic hs;
    if (cur <= last) begin
      load(cur);
      if_valid = 1'b1;
    end else begin
      if_valid = 1'b0;
    end
    @(negedge clk);
    hs = if_valid & sel_if_ready();
    @(posedge clk);
    #2;
    if (hs) cur++;
    if (cur > last) if_valid = 1'b0;
  endtask

  task automatic stream(input int first, input int last);
    int cyc;
    cyc = 0;
    cur = first;
    while (cur <= last && cyc < 50) begin
      tick_drive(last);
      cyc++;
    end
    if_valid = 1'b0;
    check("stream_timeout", 64'(cur), 64'(last + 1));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    id_ready = 1'b1;
    if_valid = 1'b0;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < 20) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("drain_qa", 64'(qa.size()), 64'd0);
    check("drain_qb", 64'(qb.size()), 64'd0);
  endtask

  // Scoreboards: push on intake handshake, pop and compare on EX handshake.
  always @(negedge clk) begin
    if (rst || id_flush) begin
      qa.delete();
    end else begin
      if (bus_a.ID_valid && bus_a.ID_ready) begin
        if (qa.size() == 0) check("a_extra_out", 64'(bus_a.ID_valid), 64'd0);
        else                check("a_out", 64'(obs_a()), 64'(qa.pop_front()));
      end
      if (bus_a.IF_valid && bus_a.IF_ready) qa.push_back(cur_exp);
    end
  end

  always @(negedge clk) begin
    if (rst || id_flush) begin
      qb.delete();
    end else begin
      if (bus_b.ID_valid && bus_b.ID_ready) begin
        if (qb.size() == 0) check("b_extra_out", 64'(bus_b.ID_valid), 64'd0);
        else                check("b_out", 64'(obs_b()), 64'(qb.pop_front()));
      end
      if (bus_b.IF_valid && bus_b.IF_ready && !cur_ill) qb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_entry(0,  32'hFFB10093, bun(4'd0, 1'b1, 32'hFFFFFFFB, 0, 0, 1, 0, 0, 0, 5'd2,  5'd27, 5'd1), 1'b0);
    set_entry(1,  32'h405201B3, bun(4'd1, 1'b0, 32'h0,        0, 0, 1, 0, 0, 0, 5'd4,  5'd5,  5'd3), 1'b0);
    set_entry(2,  32'h0063A423, bun(4'd0, 1'b1, 32'h8,        1, 0, 0, 0, 0, 0, 5'd7,  5'd6,  5'd8), 1'b0);
    set_entry(3,  32'hFFFFFFFF, bun(4'd6, 1'b0, 32'h0,        0, 0, 0, 0, 0, 1, 5'd31, 5'd31, 5'd31), 1'b1);
    set_entry(4,  32'h00C32283, bun(4'd0, 1'b1, 32'd12,       0, 1, 1, 0, 0, 0, 5'd6,  5'd12, 5'd5), 1'b0);
    set_entry(5,  32'hFE209CE3, bun(4'd1, 1'b0, 32'hFFFFFFF8, 0, 0, 0, 1, 1, 0, 5'd1,  5'd2,  5'd25), 1'b0);
    set_entry(6,  32'h00345393, bun(4'd8, 1'b1, 32'd3,        0, 0, 1, 0, 0, 0, 5'd8,  5'd3,  5'd7), 1'b0);
    set_entry(7,  32'h40345393, bun(4'd6, 1'b0, 32'h0,        0, 0, 0, 0, 0, 1, 5'd8,  5'd3,  5'd7), 1'b1);
    set_entry(8,  32'h00B574B3, bun(4'd2, 1'b0, 32'h0,        0, 0, 1, 0, 0, 0, 5'd10, 5'd11, 5'd9), 1'b0);
    set_entry(9,  32'h06412093, bun(4'd5, 1'b1, 32'd100,      0, 0, 1, 0, 0, 0, 5'd2,  5'd4,  5'd1), 1'b0);
    set_entry(10, 32'h003110B3, bun(4'd7, 1'b0, 32'h0,        0, 0, 1, 0, 0, 0, 5'd2,  5'd3,  5'd1), 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 64'(bus_a.ID_valid), 64'd0);
    check("rst_bundle", 64'(obs_a()), 64'(bun(4'd6, 0, 32'h0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0)));
    rst = 1'b0;
    #1;
    check("rst_if_ready", 64'(bus_a.IF_ready), 64'd1);
    check("rst_if_ready_b", 64'(bus_b.IF_ready), 64'd1);

    // Single word, 1-cycle latency, then full table at full throughput
    id_ready = 1'b1;
    stream(0, 0);
    check("latency_valid", 64'(bus_a.ID_valid), 64'd1);
    check("latency_bundle", 64'(obs_a()), 64'(exps[0]));
    stream(1, NW - 1);
    drain();
    check("idle_valid", 64'(bus_a.ID_valid), 64'd0);

    // Backpressure: three words offered while EX stalls
    id_ready = 1'b0;
    cur = 0;
    repeat (3) begin
      tick_drive(2);
      check("bp_hold", 64'(obs_a()), 64'(exps[0]));
    end
    check("bp_accepted", 64'(cur), 64'(CAP));
    check("bp_if_ready", 64'(bus_a.IF_ready), 64'd0);
    check("bp_valid", 64'(bus_a.ID_valid), 64'd1);
    id_ready = 1'b1;
    stream(cur, 2);
    drain();

    // Flush with the stage full and a word on offer
    id_ready = 1'b0;
    cur = 4;
    repeat (3) tick_drive(6);
    load(7);
    if_valid = 1'b1;
    id_flush = 1'b1;
    @(negedge clk);
    check("flush_if_ready_low", 64'(bus_a.IF_ready), 64'd0);
    @(posedge clk);
    #2;
    id_flush = 1'b0;
    if_valid = 1'b0;
    #1;
    check("flush_valid", 64'(bus_a.ID_valid), 64'd0);
    check("flush_if_ready", 64'(bus_a.IF_ready), 64'd1);
    @(negedge clk);
    check("flush_stays_empty", 64'(bus_a.ID_valid), 64'd0);
    id_ready = 1'b1;
    @(posedge clk);
    #2;
    stream(6, 6);
    drain();

    // Asynchronous reset mid-stream discards held words
    id_ready = 1'b0;
    cur = 8;
    repeat (2) tick_drive(9);
    rst = 1'b1;
    if_valid = 1'b0;
    #1;
    check("midrst_valid", 64'(bus_a.ID_valid), 64'd0);
    check("midrst_aluop", 64'(bus_a.ID_aluop), 64'd6);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_if_ready", 64'(bus_a.IF_ready), 64'd1);
    id_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("midrst_no_output", 64'(bus_a.ID_valid), 64'd0);

    // Drop mode: illegal words are consumed without output
    sel = 1'b1;
    stream(3, 3);
    check("drop_no_valid", 64'(bus_b.ID_valid), 64'd0);
    check("drop_if_ready", 64'(bus_b.IF_ready), 64'd1);
    stream(0, 0);
    check("drop_next_valid", 64'(bus_b.ID_valid), 64'd1);
    stream(7, 7);
    check("drop_srai", 64'(bus_b.ID_valid), 64'd0);
    stream(5, 6);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
